// File: rtl/cpu_defs.sv
// cpu_defs: shared decode-stage definitions for the redirection pipeline CPU.
//   state_e          syscall sequencer FSM states (also exported as the debug State bus)
//   SYS_*            syscall codes, compared against the full 32-bit $v0
//   REG_V0 / REG_A0  register numbers routed to read ports 1/2 while Syscall=1
package cpu_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PAUSE  = 2'd1,
    ST_RESUME = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  localparam logic [31:0] SYS_HALT  = 32'd10;
  localparam logic [31:0] SYS_PRINT = 32'd34;
  localparam logic [31:0] SYS_PAUSE = 32'd50;

  localparam logic [4:0] REG_V0 = 5'd2;
  localparam logic [4:0] REG_A0 = 5'd4;

endpackage

// File: rtl/syscall_sequencer_if.sv
// syscall_sequencer_if: decode-stage syscall bus between the pipeline and the
// syscall sequencer.
//   Pipeline -> sequencer: Syscall, ID_Valid, Opnd_Ready, V0_Data, A0_Data, Go
//   Sequencer -> pipeline: Stall, Halt, Led_Data, Cycle_Count, Syscall_Count, State
// master = pipeline side, slave = sequencer side.
interface syscall_sequencer_if #(
  parameter int CNT_W     = 32,
  parameter int SYS_CNT_W = 16
);
  logic                 Syscall;
  logic                 ID_Valid;
  logic                 Opnd_Ready;
  logic [31:0]          V0_Data;
  logic [31:0]          A0_Data;
  logic                 Go;
  logic                 Stall;
  logic                 Halt;
  logic [31:0]          Led_Data;
  logic [CNT_W-1:0]     Cycle_Count;
  logic [SYS_CNT_W-1:0] Syscall_Count;
  logic [1:0]           State;

  modport master (
    output Syscall, ID_Valid, Opnd_Ready, V0_Data, A0_Data, Go,
    input  Stall, Halt, Led_Data, Cycle_Count, Syscall_Count, State
  );

  modport slave (
    input  Syscall, ID_Valid, Opnd_Ready, V0_Data, A0_Data, Go,
    output Stall, Halt, Led_Data, Cycle_Count, Syscall_Count, State
  );
endinterface

// File: rtl/rise_edge_detect.sv
// rise_edge_detect: registers a level input and flags its rising edge.
//   clk_i   clock (rising edge)
//   rst_i   asynchronous active-high reset, clears the history flop
//   d_i     level input (not synchronised here)
//   pulse_o d_i & ~previous d_i, combinational
module rise_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);
  logic d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) d_q <= 1'b0;
    else       d_q <= d_i;
  end

  assign pulse_o = d_i & ~d_q;
endmodule

// File: rtl/syscall_sequencer.sv
// syscall_sequencer: decode-stage syscall controller.
//   LOGISIM_CLOCK_TREE_0  clock tree bundle; bit [4] is the global clock
//   Reset                 asynchronous active-high reset
//   sc                    syscall bus (slave side): operand interlock, print /
//                         pause / halt sequencing, cycle and syscall counters
// Stall is combinational and ORed into the PC and IF/ID write enables.
module syscall_sequencer
  import cpu_defs::*;
#(
  parameter int CNT_W     = 32,
  parameter int SYS_CNT_W = 16
) (
  input  logic [4:0]          LOGISIM_CLOCK_TREE_0,
  input  logic                Reset,
  syscall_sequencer_if.slave  sc
);
  logic clk;
  logic unused_clk_bits;

  assign clk             = LOGISIM_CLOCK_TREE_0[4];
  assign unused_clk_bits = ^LOGISIM_CLOCK_TREE_0[3:0];

  state_e               state_q, state_d;
  logic [31:0]          led_q;
  logic [CNT_W-1:0]     cycle_q;
  logic [SYS_CNT_W-1:0] sys_cnt_q;
  logic                 go_rise;
  logic                 sys_req;
  logic                 accept;
  logic                 stall;

  rise_edge_detect u_go_edge (
    .clk_i   (clk),
    .rst_i   (Reset),
    .d_i     (sc.Go),
    .pulse_o (go_rise)
  );

  // Bubbles may carry a stale Syscall bit; ID_Valid masks them out.
  assign sys_req = sc.Syscall & sc.ID_Valid;
  assign accept  = (state_q == ST_IDLE) & sys_req & sc.Opnd_Ready;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall = sys_req & ~sc.Opnd_Ready;
        if (accept) begin
          if (sc.V0_Data == SYS_HALT) begin
            state_d = ST_HALT;
            stall   = 1'b1;
          end else if (sc.V0_Data == SYS_PAUSE) begin
            state_d = ST_PAUSE;
            stall   = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        stall = 1'b1;
        if (go_rise) state_d = ST_RESUME;
      end
      // One unstalled cycle lets the paused syscall leave ID; accept is
      // gated by ST_IDLE, so it cannot be taken a second time.
      ST_RESUME: state_d = ST_IDLE;
      ST_HALT:   stall   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      led_q     <= '0;
      cycle_q   <= '0;
      sys_cnt_q <= '0;
    end else begin
      if (state_q != ST_HALT) cycle_q <= cycle_q + 1'b1;
      if (accept && sc.V0_Data == SYS_PRINT) led_q <= sc.A0_Data;
      if (accept && sys_cnt_q != '1) sys_cnt_q <= sys_cnt_q + 1'b1;
    end
  end

  assign sc.Stall         = stall;
  assign sc.Halt          = (state_q == ST_HALT);
  assign sc.Led_Data      = led_q;
  assign sc.Cycle_Count   = cycle_q;
  assign sc.Syscall_Count = sys_cnt_q;
  assign sc.State         = state_q;
endmodule

// File: tb/tb_syscall_sequencer.sv
module tb_syscall_sequencer;
  logic       clk = 1'b0;
  logic       rst_m;
  logic       rst_s;
  logic [4:0] tree;
  int         n_checks = 0;
  int         n_err = 0;
  logic       small_done = 1'b0;

  always #5 clk = ~clk;
  assign tree = {clk, 4'b0000};

  syscall_sequencer_if bus_m ();
  syscall_sequencer_if #(.CNT_W(4), .SYS_CNT_W(4)) bus_s ();

  syscall_sequencer u_m (
    .LOGISIM_CLOCK_TREE_0 (tree),
    .Reset                (rst_m),
    .sc                   (bus_m.slave)
  );

  syscall_sequencer #(.CNT_W(4), .SYS_CNT_W(4)) u_s (
    .LOGISIM_CLOCK_TREE_0 (tree),
    .Reset                (rst_s),
    .sc                   (bus_s.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic r,
                       input logic [31:0] v0, input logic [31:0] a0, input logic g);
    bus_m.Syscall    = s;
    bus_m.ID_Valid   = v;
    bus_m.Opnd_Ready = r;
    bus_m.V0_Data    = v0;
    bus_m.A0_Data    = a0;
    bus_m.Go         = g;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sys;
    logic        valid;
    logic        ready;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        exp_stall;
    logic [1:0]  exp_state;
    logic [31:0] exp_led;
    logic [15:0] exp_cnt;
  } vec_t;

  // Small instance: 4-bit cycle counter wrap and 4-bit syscall saturation.
  initial begin
    rst_s            = 1'b1;
    bus_s.Syscall    = 1'b1;
    bus_s.ID_Valid   = 1'b1;
    bus_s.Opnd_Ready = 1'b1;
    bus_s.V0_Data    = 32'd1;
    bus_s.A0_Data    = 32'd0;
    bus_s.Go         = 1'b0;
    #1;
    chk("s_rst_cycle", 32'(bus_s.Cycle_Count), 32'd0);
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("s_cycle_15", 32'(bus_s.Cycle_Count), 32'd15);
    chk("s_syscnt_15", 32'(bus_s.Syscall_Count), 32'd15);
    @(posedge clk);
    #1;
    chk("s_cycle_wrap", 32'(bus_s.Cycle_Count), 32'd0);
    chk("s_syscnt_sat", 32'(bus_s.Syscall_Count), 32'd15);
    small_done = 1'b1;
  end

  initial begin
    vec_t vecs[9];
    int   cnt_wait;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'd10,        32'h0,        1'b0, 2'd0, 32'h0,        16'd0}; // stale bubble
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'd34,        32'hDEADBEEF, 1'b1, 2'd0, 32'h0,        16'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'd34,        32'hDEADBEEF, 1'b1, 2'd0, 32'h0,        16'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'd34,        32'hDEADBEEF, 1'b0, 2'd0, 32'hDEADBEEF, 16'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'd1,         32'h12345678, 1'b0, 2'd0, 32'hDEADBEEF, 16'd2};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'd34,        32'h5,        1'b0, 2'd0, 32'hDEADBEEF, 16'd2};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'd7,         32'h0,        1'b1, 2'd0, 32'hDEADBEEF, 16'd2};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_0122, 32'h77,       1'b0, 2'd0, 32'hDEADBEEF, 16'd3}; // 34+256: nop
    vecs[8] = '{1'b0, 1'b0, 1'b0, 32'd0,         32'h0,        1'b0, 2'd0, 32'hDEADBEEF, 16'd3};

    rst_m = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    chk("rst_state", 32'(bus_m.State), 32'd0);
    chk("rst_halt", 32'(bus_m.Halt), 32'd0);
    chk("rst_led", bus_m.Led_Data, 32'd0);
    chk("rst_cycle", bus_m.Cycle_Count, 32'd0);
    chk("rst_syscnt", 32'(bus_m.Syscall_Count), 32'd0);
    chk("rst_stall", 32'(bus_m.Stall), 32'd0);
    tick();
    chk("rst_hold_cycle", bus_m.Cycle_Count, 32'd0);
    rst_m = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].sys, vecs[i].valid, vecs[i].ready, vecs[i].v0, vecs[i].a0, 1'b0);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus_m.Stall), 32'(vecs[i].exp_stall));
      tick();
      chk($sformatf("v%0d_state", i), 32'(bus_m.State), 32'(vecs[i].exp_state));
      chk($sformatf("v%0d_halt", i), 32'(bus_m.Halt), 32'd0);
      chk($sformatf("v%0d_led", i), bus_m.Led_Data, vecs[i].exp_led);
      chk($sformatf("v%0d_syscnt", i), 32'(bus_m.Syscall_Count), 32'(vecs[i].exp_cnt));
    end

    // Pause entered with Go already high: needs a fresh rising edge.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'd50, 32'd0, 1'b1);
    #1;
    chk("pause_acc_stall", 32'(bus_m.Stall), 32'd1);
    tick();
    chk("pause_state", 32'(bus_m.State), 32'd1);
    chk("pause_syscnt", 32'(bus_m.Syscall_Count), 32'd4);
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("pause_hold_stall", 32'(bus_m.Stall), 32'd1);
      tick();
      chk("pause_hold_state", 32'(bus_m.State), 32'd1);
    end
    bus_m.Go = 1'b0;
    tick();
    chk("pause_golow_state", 32'(bus_m.State), 32'd1);
    bus_m.Go = 1'b1;
    #1;
    chk("pause_gorise_stall", 32'(bus_m.Stall), 32'd1);
    tick();
    chk("resume_state", 32'(bus_m.State), 32'd2);
    chk("resume_stall", 32'(bus_m.Stall), 32'd0);
    chk("resume_syscnt", 32'(bus_m.Syscall_Count), 32'd4);
    tick();
    chk("post_resume_state", 32'(bus_m.State), 32'd0);
    chk("post_resume_syscnt", 32'(bus_m.Syscall_Count), 32'd4);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Asynchronous reset mid-run at Cycle_Count=57.
    cnt_wait = 0;
    while (bus_m.Cycle_Count != 32'd57 && cnt_wait < 200) begin
      tick();
      cnt_wait++;
    end
    chk("reach_57", bus_m.Cycle_Count, 32'd57);
    #2;
    rst_m = 1'b1;
    #1;
    chk("mid_rst_cycle", bus_m.Cycle_Count, 32'd0);
    chk("mid_rst_led", bus_m.Led_Data, 32'd0);
    chk("mid_rst_syscnt", 32'(bus_m.Syscall_Count), 32'd0);
    chk("mid_rst_state", 32'(bus_m.State), 32'd0);
    tick();
    rst_m = 1'b0;

    // Halt accepted at Cycle_Count=100.
    cnt_wait = 0;
    while (bus_m.Cycle_Count != 32'd100 && cnt_wait < 200) begin
      tick();
      cnt_wait++;
    end
    chk("reach_100", bus_m.Cycle_Count, 32'd100);
    drive(1'b1, 1'b1, 1'b1, 32'd10, 32'h55, 1'b0);
    #1;
    chk("halt_acc_stall", 32'(bus_m.Stall), 32'd1);
    chk("halt_acc_halt", 32'(bus_m.Halt), 32'd0);
    tick();
    chk("halt_halt", 32'(bus_m.Halt), 32'd1);
    chk("halt_state", 32'(bus_m.State), 32'd3);
    chk("halt_cycle", bus_m.Cycle_Count, 32'd101);
    chk("halt_syscnt", 32'(bus_m.Syscall_Count), 32'd1);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 1'b1, (k % 2 == 0) ? 32'd34 : 32'd50, 32'hCAFE0000 + 32'(k), 1'(k % 2));
      #1;
      chk("halted_stall", 32'(bus_m.Stall), 32'd1);
      tick();
      chk("halted_state", 32'(bus_m.State), 32'd3);
      chk("halted_cycle", bus_m.Cycle_Count, 32'd101);
      chk("halted_led", bus_m.Led_Data, 32'd0);
      chk("halted_syscnt", 32'(bus_m.Syscall_Count), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #2;
    rst_m = 1'b1;
    #1;
    chk("halt_rst_state", 32'(bus_m.State), 32'd0);
    chk("halt_rst_halt", 32'(bus_m.Halt), 32'd0);
    chk("halt_rst_stall", 32'(bus_m.Stall), 32'd0);
    tick();
    rst_m = 1'b0;

    // Syscall counter saturation with back-to-back nops.
    drive(1'b1, 1'b1, 1'b1, 32'd1, 32'd0, 1'b0);
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_reach", 32'(bus_m.Syscall_Count), 32'h0000FFFF);
    chk("sat_nop_stall", 32'(bus_m.Stall), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_hold", 32'(bus_m.Syscall_Count), 32'h0000FFFF);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    chk("small_done", 32'(small_done), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
